// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with a tear-free shadow/commit display register.
// Optional build macro LEADING_ZERO_BLANK_EN: blank leading zero digits (digit 0 always shown).
module seg_scan_ctrl #(
  parameter int DIGITS    = 4,
  parameter int DIV       = 1024,
  parameter int BLANK_CYC = 16
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  EN,
  input  logic                  LOAD,
  input  logic [4*DIGITS-1:0]   DIN,
  output logic [6:0]            SEG,
  output logic [DIGITS-1:0]     SEL,
  output logic                  FRAME,
  output logic [1:0]            dbg_state
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PH_LAST       = PW'(DIV - 1);
  localparam logic [PW-1:0] PH_BLANK_LAST = PW'(BLANK_CYC - 1);
  localparam logic [IW-1:0] IDX_LAST      = IW'(DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [PW-1:0]         phase_q, phase_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [4*DIGITS-1:0]   shadow_q, shadow_d;
  logic [4*DIGITS-1:0]   disp_q, disp_d;
  logic                  pend_q, pend_d;
  logic [6:0]            seg_d;
  logic [DIGITS-1:0]     sel_d;
  logic                  frame_d;

  assign dbg_state = state_q;

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    case (nib)
      4'h0: seg_decode = 7'b1111110;
      4'h1: seg_decode = 7'b0110000;
      4'h2: seg_decode = 7'b1101101;
      4'h3: seg_decode = 7'b1111001;
      4'h4: seg_decode = 7'b0110011;
      4'h5: seg_decode = 7'b1011011;
      4'h6: seg_decode = 7'b1011111;
      4'h7: seg_decode = 7'b1110000;
      4'h8: seg_decode = 7'b1111111;
      4'h9: seg_decode = 7'b1111011;
      4'hA: seg_decode = 7'b1110111;
      4'hB: seg_decode = 7'b0011111;
      4'hC: seg_decode = 7'b1001110;
      4'hD: seg_decode = 7'b0111101;
      4'hE: seg_decode = 7'b1001111;
      default: seg_decode = 7'b1000111;
    endcase
  endfunction

  // Scan sequencing: each slot is BLANK_CYC dark cycles then lit until phase DIV-1.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    idx_d   = idx_q;
    if (state_q != IDLE && !EN) begin
      state_d = IDLE;
      phase_d = '0;
      idx_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          phase_d = '0;
          idx_d   = '0;
          if (EN) state_d = BLANK;
        end
        BLANK: begin
          phase_d = phase_q + PW'(1);
          if (phase_q == PH_BLANK_LAST) state_d = SHOW;
        end
        SHOW: begin
          if (phase_q == PH_LAST) begin
            phase_d = '0;
            idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            state_d = BLANK;
          end else begin
            phase_d = phase_q + PW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          phase_d = '0;
          idx_d   = '0;
        end
      endcase
    end
  end

  // LOAD is a single-cycle strobe with no backpressure: DIN lands in the shadow
  // and is committed on the frame-wrap edge (FRAME high) or at once while idle.
  always_comb begin
    disp_d   = disp_q;
    shadow_d = shadow_q;
    pend_d   = pend_q;
    if (FRAME) begin
      if (LOAD) begin
        disp_d   = DIN;
        shadow_d = DIN;
        pend_d   = 1'b0;
      end else if (pend_q) begin
        disp_d = shadow_q;
        pend_d = 1'b0;
      end
    end else begin
      if (state_q == IDLE && pend_q) begin
        disp_d = shadow_q;
        pend_d = 1'b0;
      end
      if (LOAD) begin
        shadow_d = DIN;
        pend_d   = 1'b1;
      end
    end
  end

  // Outputs are computed from next-state values so the registers line up with the state.
  always_comb begin
    sel_d   = '0;
    seg_d   = '0;
    frame_d = 1'b0;
    if (state_d == SHOW) begin
      sel_d   = DIGITS'(1) << idx_d;
      seg_d   = seg_decode(disp_d[{idx_d, 2'b00} +: 4]);
`ifdef LEADING_ZERO_BLANK_EN
      if (idx_d != '0 && (disp_d >> {idx_d, 2'b00}) == '0) seg_d = '0;
`endif
      frame_d = (idx_d == IDX_LAST) && (phase_d == PH_LAST);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q  <= EN ? BLANK : IDLE;
      phase_q  <= '0;
      idx_q    <= '0;
      shadow_q <= '0;
      disp_q   <= '0;
      pend_q   <= 1'b0;
      SEG      <= '0;
      SEL      <= '0;
      FRAME    <= 1'b0;
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      disp_q   <= disp_d;
      pend_q   <= pend_d;
      SEG      <= seg_d;
      SEL      <= sel_d;
      FRAME    <= frame_d;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Bench for seg_scan_ctrl: time-indexed scan model feeding an expected queue, plus directed
// literal checks and randomized EN/LOAD/RST traffic.
module tb_seg_scan_ctrl;

  localparam int DIGITS    = 2;
  localparam int DIV       = 8;
  localparam int BLANK_CYC = 2;
  localparam int DW        = 4 * DIGITS;
  localparam int EW        = 1 + DIGITS + 7;
  localparam int SCAN      = DIV * DIGITS;

  // clock / reset / inputs
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic load = 1'b0;
  logic [DW-1:0] din = '0;
  logic [6:0] seg;
  logic [DIGITS-1:0] sel;
  logic frame;
  logic [1:0] dbg_state;

  always #5 clk = ~clk;

  seg_scan_ctrl #(.DIGITS(DIGITS), .DIV(DIV), .BLANK_CYC(BLANK_CYC)) dut (
    .CLK(clk), .RST(rst), .EN(en), .LOAD(load), .DIN(din),
    .SEG(seg), .SEL(sel), .FRAME(frame), .dbg_state(dbg_state)
  );

  int checks = 0;
  int errors = 0;
  logic [EW-1:0] exp_q[$];

  // model: running flag plus elapsed time within the scan
  bit m_run = 1'b0;
  bit m_pend = 1'b0;
  bit m_chk_on = 1'b0;
  int unsigned m_t = 0;
  logic [DW-1:0] m_disp = '0;
  logic [DW-1:0] m_shadow = '0;

  logic [6:0] seg_tab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_out();
    int unsigned ph;
    int unsigned sl;
    logic [DIGITS-1:0] s;
    logic [6:0] g;
    logic f;
    ph = m_t % DIV;
    sl = m_t / DIV;
    s = '0;
    g = '0;
    f = 1'b0;
    if (m_run && ph >= BLANK_CYC) begin
      s = DIGITS'(1) << sl;
      g = seg_tab[4'(m_disp >> (4 * sl))];
`ifdef LEADING_ZERO_BLANK_EN
      if (sl > 0 && (m_disp >> (4 * sl)) == '0) g = '0;
`endif
      f = (sl == DIGITS - 1) && (ph == DIV - 1);
    end
    return {f, s, g};
  endfunction

  function automatic bit model_frame();
    logic [EW-1:0] o;
    o = model_out();
    return o[EW-1];
  endfunction

  task automatic model_step();
    bit fr;
    fr = model_frame();
    if (rst) begin
      m_run = en;
      m_t = 0;
      m_disp = '0;
      m_shadow = '0;
      m_pend = 1'b0;
      m_chk_on = 1'b1;
    end else begin
      if (fr) begin
        if (load) begin
          m_disp = din;
          m_shadow = din;
          m_pend = 1'b0;
        end else if (m_pend) begin
          m_disp = m_shadow;
          m_pend = 1'b0;
        end
      end else begin
        if (!m_run && m_pend) begin
          m_disp = m_shadow;
          m_pend = 1'b0;
        end
        if (load) begin
          m_shadow = din;
          m_pend = 1'b1;
        end
      end
      if (!m_run) begin
        m_run = en;
        m_t = 0;
      end else if (!en) begin
        m_run = 1'b0;
        m_t = 0;
      end else begin
        m_t = (m_t + 1) % SCAN;
      end
    end
    if (m_chk_on) exp_q.push_back(model_out());
  endtask

  // driver: one clock cycle; inputs change only at the falling edge
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  // scoreboard compare
  initial begin : cmp_proc
    logic [EW-1:0] e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("frame_model", 32'(frame), 32'(e[EW-1]));
        chk("sel_model", 32'(sel), 32'(e[7 +: DIGITS]));
        chk("seg_model", 32'(seg), 32'(e[6:0]));
      end
    end
  end

  initial begin
    logic [6:0] lz_seg;
`ifdef LEADING_ZERO_BLANK_EN
    lz_seg = 7'b0000000;
`else
    lz_seg = 7'b1111110;
`endif
    rst = 1'b1;
    en = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    // directed sequence: c is the cycle index after reset release
    for (int c = 0; c < 126; c++) begin
      case (c)
        0: begin
          chk("rst_sel", 32'(sel), 32'h0);
          chk("rst_seg", 32'(seg), 32'h0);
          chk("rst_frame", 32'(frame), 32'h0);
        end
        1: chk("blank1_sel", 32'(sel), 32'h0);
        2: begin
          chk("d0_first_sel", 32'(sel), 32'b01);
          chk("d0_first_seg", 32'(seg), 32'b1111110);
        end
        7: chk("d0_last_sel", 32'(sel), 32'b01);
        8: chk("blank_gap_sel", 32'(sel), 32'h0);
        10: begin
          chk("d1_sel", 32'(sel), 32'b10);
          chk("d1_seg", 32'(seg), 32'b1111110);
        end
        12: chk("no_midframe_commit", 32'(seg), 32'b1111110);
        14: chk("frame_early", 32'(frame), 32'h0);
        15: begin
          chk("frame_pulse", 32'(frame), 32'h1);
          chk("frame_sel", 32'(sel), 32'b10);
        end
        16: chk("frame_clear", 32'(frame), 32'h0);
        18: begin
          chk("commit_d0_sel", 32'(sel), 32'b01);
          chk("commit_d0_seg", 32'(seg), 32'b1110111);
        end
        26: begin
          chk("commit_d1_sel", 32'(sel), 32'b10);
          chk("commit_d1_seg", 32'(seg), 32'b1111001);
        end
        50: chk("last_load_d0", 32'(seg), 32'b0110011);
        58: chk("last_load_d1", 32'(seg), 32'b1111001);
        66: chk("frame_load_d0", 32'(seg), 32'b1011111);
        74: chk("frame_load_d1", 32'(seg), 32'b1011011);
        82: chk("v05_d0_seg", 32'(seg), 32'b1011011);
        90: begin
          chk("v05_d1_sel", 32'(sel), 32'b10);
          chk("v05_d1_seg", 32'(seg), 32'(lz_seg));
        end
        101: begin
          chk("en_off_sel", 32'(sel), 32'h0);
          chk("en_off_seg", 32'(seg), 32'h0);
        end
        107: chk("en_on_blank", 32'(sel), 32'h0);
        108: begin
          chk("en_on_sel", 32'(sel), 32'b01);
          chk("en_on_retained", 32'(seg), 32'b1011011);
        end
        119: begin
          chk("midrst_sel", 32'(sel), 32'h0);
          chk("midrst_seg", 32'(seg), 32'h0);
          chk("midrst_frame", 32'(frame), 32'h0);
        end
        121: begin
          chk("midrst_restart_sel", 32'(sel), 32'b01);
          chk("midrst_cleared_seg", 32'(seg), 32'b1111110);
        end
        default: ;
      endcase
      load = 1'b0;
      rst = 1'b0;
      case (c)
        4: begin load = 1'b1; din = 8'h3A; end
        33: begin load = 1'b1; din = 8'h12; end
        36: begin load = 1'b1; din = 8'h34; end
        63: begin load = 1'b1; din = 8'h56; end
        70: begin load = 1'b1; din = 8'h05; end
        100: en = 1'b0;
        105: en = 1'b1;
        118: rst = 1'b1;
        default: ;
      endcase
      tick();
    end
    // randomized traffic, with extra LOADs aimed at FRAME cycles
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 59) == 0) en = ~en;
      load = ($urandom_range(0, 15) == 0) || (model_frame() && $urandom_range(0, 1) == 1);
      din = DW'($urandom);
      tick();
    end
    rst = 1'b0;
    load = 1'b0;
    repeat (2) tick();
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
